// File: rtl/pong_scene_renderer.sv
// pong_scene_renderer: two-stage pixel renderer for a pong scene (border, paddles, 8x8 ball, score flash)
//   clk, reset        rising-edge clock, synchronous active-high reset
//   frame_start       latches the position inputs into shadow registers; advances the flash counter
//   pixel_valid, x, y pixel coordinate qualified for rendering
//   paddle_*_pos      paddle top lines; ball_pos_x/y top-left of the ball sprite
//   score_event       (re)starts the border flash
//   out_valid, game_on, game_rgb   rendered pixel, two cycles after its coordinate
module pong_scene_renderer #(
    parameter int          SCREEN_W      = 640,
    parameter int          SCREEN_H      = 480,
    parameter int          PADDLE_W      = 5,
    parameter int          PADDLE_H      = 50,
    parameter int          PADDLE_MARGIN = 10,
    parameter int          BORDER_T      = 2,
    parameter int          FLASH_FRAMES  = 32,
    parameter logic [11:0] FG_COLOR      = 12'hFFF,
    parameter logic [11:0] BALL_COLOR    = 12'hFF0,
    parameter logic [11:0] FLASH_COLOR   = 12'hF00,
    parameter logic [11:0] BG_COLOR      = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  paddle_left_pos,
    input  logic [9:0]  paddle_right_pos,
    input  logic [9:0]  ball_pos_x,
    input  logic [9:0]  ball_pos_y,
    input  logic        score_event,
    output logic        out_valid,
    output logic        game_on,
    output logic [11:0] game_rgb
);
    localparam logic [10:0] BT  = 11'(BORDER_T);
    localparam logic [10:0] BB  = 11'(SCREEN_H - BORDER_T);
    localparam logic [10:0] PH  = 11'(PADDLE_H);
    localparam logic [10:0] LX0 = 11'(PADDLE_MARGIN);
    localparam logic [10:0] LX1 = 11'(PADDLE_MARGIN + PADDLE_W);
    localparam logic [10:0] RX0 = 11'(SCREEN_W - PADDLE_MARGIN - PADDLE_W);
    localparam logic [10:0] RX1 = 11'(SCREEN_W - PADDLE_MARGIN);
    localparam logic [7:0]  FLASH_CNT = 8'(FLASH_FRAMES);
    // Row 0 occupies the top byte; bit index {~row,~col} selects bit (7-col) of row.
    localparam logic [63:0] SPRITE = 64'h3C7EFFFFFFFF7E3C;

    typedef enum logic {IDLE, FLASH} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        flashing;
    logic [9:0]  l_sh, r_sh, bx_sh, by_sh;
    logic [10:0] xe, ye, l0, r0, bx0, by0;
    logic        hit_border, hit_paddle, hit_box;
    logic        v1, b1, p1, box1, sprite_on;
    logic [2:0]  row1, col1;

    always_ff @(posedge clk) begin
        if (reset) begin
            l_sh  <= '0;
            r_sh  <= '0;
            bx_sh <= '0;
            by_sh <= '0;
        end else if (frame_start) begin
            l_sh  <= paddle_left_pos;
            r_sh  <= paddle_right_pos;
            bx_sh <= ball_pos_x;
            by_sh <= ball_pos_y;
        end
    end

    // Zero-extended to 11 bits so pos+size cannot wrap past 1023.
    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};
    assign l0  = {1'b0, l_sh};
    assign r0  = {1'b0, r_sh};
    assign bx0 = {1'b0, bx_sh};
    assign by0 = {1'b0, by_sh};

    always_comb begin
        hit_border = ye < BT || ye >= BB;
        hit_paddle = (ye >= l0 && ye < l0 + PH && xe >= LX0 && xe < LX1) ||
                     (ye >= r0 && ye < r0 + PH && xe >= RX0 && xe < RX1);
        hit_box    = xe >= bx0 && xe < bx0 + 11'd8 && ye >= by0 && ye < by0 + 11'd8;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1   <= 1'b0;
            b1   <= 1'b0;
            p1   <= 1'b0;
            box1 <= 1'b0;
            row1 <= '0;
            col1 <= '0;
        end else begin
            v1   <= pixel_valid;
            b1   <= hit_border;
            p1   <= hit_paddle;
            box1 <= hit_box;
            row1 <= y[2:0] - by_sh[2:0];
            col1 <= x[2:0] - bx_sh[2:0];
        end
    end

    assign sprite_on = box1 && SPRITE[{~row1, ~col1}];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            game_on   <= 1'b0;
            game_rgb  <= BG_COLOR;
        end else begin
            out_valid <= v1;
            game_on   <= v1 && (sprite_on || p1 || b1);
            game_rgb  <= !v1      ? BG_COLOR :
                         sprite_on ? BALL_COLOR :
                         p1        ? FG_COLOR :
                         b1        ? (flashing ? FLASH_COLOR : FG_COLOR) : BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A score reloads the counter even when it coincides with frame_start.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (score_event) begin
            state_n = FLASH;
            cnt_n   = FLASH_CNT;
        end else if (state == FLASH && frame_start) begin
            state_n = cnt == 8'd1 ? IDLE : FLASH;
            cnt_n   = cnt - 8'd1;
        end
    end

    always_comb flashing = state == FLASH && cnt[2];
endmodule

// File: tb/tb_pong_scene_renderer.sv
// tb_pong_scene_renderer: directed and randomized checks of pong_scene_renderer against a behavioural model
module tb_pong_scene_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic [9:0]  paddle_left_pos = '0, paddle_right_pos = '0;
    logic [9:0]  ball_pos_x = '0, ball_pos_y = '0;
    logic        score_event = 1'b0;
    logic        out_valid, game_on;
    logic [11:0] game_rgb;

    int n_checks = 0;
    int n_fail = 0;
    int m_l = 0, m_r = 0, m_bx = 0, m_by = 0, m_cnt = 0;
    logic [7:0] sprite [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

    pong_scene_renderer dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .x(x), .y(y), .paddle_left_pos(paddle_left_pos), .paddle_right_pos(paddle_right_pos),
        .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y), .score_event(score_event),
        .out_valid(out_valid), .game_on(game_on), .game_rgb(game_rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {valid,on,rgb}=%h expected %h", tag, got, exp);
        end
    endtask

    // Expected {valid,on,rgb} for a visible pixel, straight from the scene rules.
    function automatic logic [13:0] model(input int px, input int py);
        bit flash_on = m_cnt > 0 && (m_cnt & 4) != 0;
        if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8 &&
            sprite[py - m_by][7 - (px - m_bx)])
            return 14'h3FF0;
        if (py >= m_l && py < m_l + 50 && px >= 10 && px < 15) return 14'h3FFF;
        if (py >= m_r && py < m_r + 50 && px >= 625 && px < 630) return 14'h3FFF;
        if (py < 2 || py >= 478) return flash_on ? 14'h3F00 : 14'h3FFF;
        return 14'h2000;
    endfunction

    task automatic pix(input int px, input int py, input logic [13:0] exp, input string tag);
        x = 10'(px);
        y = 10'(py);
        pixel_valid = 1'b1;
        @(posedge clk);
        #1 pixel_valid = 1'b0;
        @(posedge clk);
        #1 chk(tag, {out_valid, game_on, game_rgb}, exp);
    endtask

    task automatic pulse(input bit fs, input bit se);
        frame_start = fs;
        score_event = se;
        @(posedge clk);
        #1 frame_start = 1'b0;
        score_event = 1'b0;
        if (se) m_cnt = 32;
        else if (fs && m_cnt > 0) m_cnt = m_cnt - 1;
        if (fs) begin
            m_l = paddle_left_pos; m_r = paddle_right_pos;
            m_bx = ball_pos_x; m_by = ball_pos_y;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_l = 0; m_r = 0; m_bx = 0; m_by = 0; m_cnt = 0;
    endtask

    initial begin
        int px, py, mode;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", {out_valid, game_on, game_rgb}, 14'h0000);
        reset = 1'b0;
        paddle_left_pos = 10'd100; paddle_right_pos = 10'd200;
        ball_pos_x = 10'd400; ball_pos_y = 10'd300;
        pix(12, 10, 14'h3FFF, "shadow_zero_after_reset");
        pulse(1, 0);
        pix(12, 120, 14'h3FFF, "left_paddle_hit");
        pix(15, 120, 14'h2000, "left_paddle_x_edge");
        pix(12, 150, 14'h2000, "left_paddle_y_edge");
        pix(627, 210, 14'h3FFF, "right_paddle_hit");
        pix(630, 210, 14'h2000, "right_paddle_x_edge");
        pix(300, 1, 14'h3FFF, "border_top");
        pix(300, 2, 14'h2000, "border_top_edge");
        pix(300, 477, 14'h2000, "border_bot_edge");
        pix(300, 478, 14'h3FFF, "border_bot");
        paddle_left_pos = 10'd300;
        pix(12, 120, 14'h3FFF, "tear_free_old_L");
        pulse(1, 0);
        pix(12, 120, 14'h2000, "new_L_old_row_miss");
        pix(12, 310, 14'h3FFF, "new_L_hit");
        ball_pos_x = 10'd200; ball_pos_y = 10'd200;
        pulse(1, 0);
        pix(200, 200, 14'h2000, "ball_corner_transparent");
        pix(202, 200, 14'h3FF0, "ball_row0");
        pix(200, 202, 14'h3FF0, "ball_row2");
        pix(201, 207, 14'h2000, "ball_row7_transparent");
        pix(208, 203, 14'h2000, "ball_right_edge");
        paddle_left_pos = 10'd100; ball_pos_x = 10'd8; ball_pos_y = 10'd100;
        pulse(1, 0);
        pix(12, 102, 14'h3FF0, "ball_over_paddle");
        paddle_left_pos = 10'd1000;
        pulse(1, 0);
        pix(12, 2, 14'h2000, "paddle_no_wrap_1000");
        paddle_left_pos = 10'd1020;
        pulse(1, 0);
        pix(12, 5, 14'h2000, "paddle_no_wrap_1020");
        pix(12, 1022, 14'h3FFF, "offscreen_paddle_hit");
        x = 10'd300; y = 10'd0; pixel_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pixel_valid_low", {out_valid, game_on, game_rgb}, 14'h0000);
        pulse(0, 1);
        pix(300, 0, 14'h3FFF, "flash_cnt32");
        for (int i = 1; i <= 32; i++) begin
            pulse(1, 0);
            pix(300, 0, ((32 - i) & 4) != 0 ? 14'h3F00 : 14'h3FFF, "flash_frame");
        end
        pulse(1, 0);
        pix(300, 0, 14'h3FFF, "flash_idle");
        pulse(0, 1);
        repeat (27) pulse(1, 0);
        pix(300, 0, 14'h3F00, "flash_cnt5");
        pulse(1, 1);
        pix(300, 0, 14'h3FFF, "retrigger_cnt32");
        pulse(1, 0);
        pix(300, 0, 14'h3F00, "retrigger_cnt31");
        do_reset();
        pix(300, 0, 14'h3FFF, "reset_mid_flash");
        pix(12, 10, 14'h3FFF, "reset_shadows_zero");
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0: begin
                    paddle_left_pos = 10'($urandom_range(0, 1023));
                    paddle_right_pos = 10'($urandom_range(0, 1023));
                    ball_pos_x = 10'($urandom_range(0, 1023));
                    ball_pos_y = 10'($urandom_range(0, 1023));
                    pulse(1, 0);
                end
                1: pulse($urandom_range(0, 1) == 1, 1);
                2: pulse(1, 0);
                3: begin
                    paddle_left_pos = 10'($urandom_range(0, 1023));
                    ball_pos_x = 10'($urandom_range(0, 1023));
                end
                default: begin
                    mode = $urandom_range(0, 3);
                    px = $urandom_range(0, 1023);
                    py = $urandom_range(0, 1023);
                    if (mode == 1) begin
                        px = (m_bx + $urandom_range(0, 11) - 2) & 1023;
                        py = (m_by + $urandom_range(0, 11) - 2) & 1023;
                    end else if (mode == 2) begin
                        px = $urandom_range(0, 1) == 1 ? $urandom_range(8, 17) : $urandom_range(622, 632);
                        py = ((px < 300 ? m_l : m_r) + $urandom_range(0, 55) - 3) & 1023;
                    end else if (mode == 3) begin
                        px = $urandom_range(0, 700);
                        py = $urandom_range(0, 1) == 1 ? $urandom_range(0, 3) : $urandom_range(476, 481);
                    end
                    pix(px, py, model(px, py), "random_pixel");
                end
            endcase
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
